// File: rtl/queue2_pkg.sv
// -----------------------------------------------------------------------------
// queue2_pkg
// Shared defaults and helpers for the queue2_ctrl FIFO controller.
//   QUEUE2_DATA_W : default payload width in bits
//   QUEUE2_DEPTH  : default entry count (power of two, minimum 2)
//   count_w()     : width of the occupancy count, log2(depth)+1, so that a
//                   full queue (count == depth) is representable
// -----------------------------------------------------------------------------
package queue2_pkg;

  localparam int unsigned QUEUE2_DATA_W = 105;
  localparam int unsigned QUEUE2_DEPTH  = 2;

  function automatic int unsigned count_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/queue_ptr.sv
// -----------------------------------------------------------------------------
// queue_ptr
// Wrapping pointer for one side of the queue. Advances by one on inc, wraps
// DEPTH-1 -> 0, and returns to zero on clear (clear wins over inc).
// Ports:
//   clock   : sole clock, rising edge
//   reset_n : asynchronous active-low reset, pointer -> 0
//   clear   : synchronous return to zero at the next edge
//   inc     : advance the pointer by one at the next edge
//   ptr     : current pointer value, log2(DEPTH) bits
// -----------------------------------------------------------------------------
module queue_ptr #(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     inc,
  output logic [$clog2(DEPTH)-1:0] ptr
);

  localparam int unsigned     AW   = $clog2(DEPTH);
  localparam logic [AW-1:0]   LAST = AW'(DEPTH - 1);

  logic [AW-1:0] ptr_q;
  logic [AW-1:0] ptr_d;

  always_comb begin
    // NOTE: default assignment first so every path assigns ptr_d; no latch.
    ptr_d = ptr_q;
    if (clear) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
    end
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/queue2_ctrl.sv
// -----------------------------------------------------------------------------
// queue2_ctrl
// Control logic for a DEPTH-entry FIFO whose payload lives in an external
// RAM with one synchronous write port (W0) and one combinational read port
// (R0). Only the two pointers and the maybe_full flag are held here.
//
// Optional feature: define QUEUE2_CTRL_FLOW_EN to enable the zero-latency
// bypass. When the queue is empty, the incoming entry is presented directly
// on the dequeue side; if the consumer takes it the same cycle, nothing is
// written and the pointers do not move. Without the macro, an enqueued entry
// becomes visible on deq_valid one cycle after it is written.
//
// Ports:
//   clock, reset_n               : clock and asynchronous active-low reset
//   flush                        : synchronous discard of all entries
//   enq_valid/enq_ready/enq_bits : producer handshake
//   deq_valid/deq_ready/deq_bits : consumer handshake
//   count                        : number of stored entries, 0..DEPTH
//   mem_W0_en/addr/data          : RAM write port drive
//   mem_R0_en/addr, mem_R0_data  : RAM read port (combinational read data)
// -----------------------------------------------------------------------------
module queue2_ctrl
  import queue2_pkg::*;
#(
  parameter int unsigned DATA_W = QUEUE2_DATA_W,
  parameter int unsigned DEPTH  = QUEUE2_DEPTH
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      flush,
  input  logic                      enq_valid,
  output logic                      enq_ready,
  input  logic [DATA_W-1:0]         enq_bits,
  output logic                      deq_valid,
  input  logic                      deq_ready,
  output logic [DATA_W-1:0]         deq_bits,
  output logic [count_w(DEPTH)-1:0] count,
  output logic                      mem_W0_en,
  output logic [$clog2(DEPTH)-1:0]  mem_W0_addr,
  output logic [DATA_W-1:0]         mem_W0_data,
  output logic                      mem_R0_en,
  output logic [$clog2(DEPTH)-1:0]  mem_R0_addr,
  input  logic [DATA_W-1:0]         mem_R0_data
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0] enq_ptr;
  logic [AW-1:0] deq_ptr;
  logic [AW-1:0] ptr_diff;
  logic          maybe_full_q;
  logic          maybe_full_d;
  logic          ptr_match;
  logic          empty;
  logic          full;
  logic          do_enq;
  logic          do_deq;

  // Equal pointers mean either empty or full; maybe_full tells them apart.
  assign ptr_match = (enq_ptr == deq_ptr);
  assign empty     = ptr_match & ~maybe_full_q;
  assign full      = ptr_match &  maybe_full_q;

  // Flush blocks both handshakes so no transfer coincides with the discard.
  assign enq_ready = ~full & ~flush;

`ifdef QUEUE2_CTRL_FLOW_EN
  // Empty queue: the producer's entry is offered straight to the consumer.
  // If it is taken now, it never touches the RAM or the pointers.
  assign deq_valid = (~empty | enq_valid) & ~flush;
  assign deq_bits  = empty ? enq_bits : mem_R0_data;
  assign do_enq    = enq_valid & enq_ready & ~(empty & deq_ready);
  assign do_deq    = deq_valid & deq_ready & ~empty;
`else
  assign deq_valid = ~empty & ~flush;
  assign deq_bits  = mem_R0_data;
  assign do_enq    = enq_valid & enq_ready;
  assign do_deq    = deq_valid & deq_ready;
`endif

  // enq_ready stays high during reset, so the write strobe is also qualified
  // by reset_n to keep the RAM from being written while reset is held.
  assign mem_W0_en   = do_enq & reset_n;
  assign mem_W0_addr = enq_ptr;
  assign mem_W0_data = enq_bits;

  // Never read while empty: RAM contents left over from before a reset or
  // flush are stale and must not be observed until rewritten.
  assign mem_R0_en   = ~empty;
  assign mem_R0_addr = deq_ptr;

  // Pointer difference wraps modulo DEPTH; the top bit marks the full case.
  assign ptr_diff = enq_ptr - deq_ptr;
  assign count    = {maybe_full_q & ptr_match, ptr_diff};

  queue_ptr #(.DEPTH(DEPTH)) u_enq_ptr (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (flush),
    .inc     (do_enq),
    .ptr     (enq_ptr)
  );

  queue_ptr #(.DEPTH(DEPTH)) u_deq_ptr (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (flush),
    .inc     (do_deq),
    .ptr     (deq_ptr)
  );

  // An unbalanced transfer moves occupancy toward full (enq) or empty (deq);
  // a balanced cycle leaves the full/empty ambiguity unchanged.
  always_comb begin
    maybe_full_d = maybe_full_q;
    if (flush) begin
      maybe_full_d = 1'b0;
    end else if (do_enq != do_deq) begin
      maybe_full_d = do_enq;
    end
  end

  // NOTE: only control state is reset; the payload RAM is deliberately left
  // uninitialised because empty/full tracking guarantees it is never read
  // before being written.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      maybe_full_q <= 1'b0;
    end else begin
      maybe_full_q <= maybe_full_d;
    end
  end

endmodule

// File: tb/tb_queue2_ctrl.sv
// -----------------------------------------------------------------------------
// tb_queue2_ctrl
// Directed self-checking bench for queue2_ctrl at default parameters
// (DATA_W=105, DEPTH=2). A small behavioural RAM is attached to the W0/R0
// ports. Inputs change 1 time unit after the rising edge; outputs are checked
// on the falling edge.
// -----------------------------------------------------------------------------
module tb_queue2_ctrl;

  localparam int DW = 105;

  logic          clock;
  logic          reset_n;
  logic          flush;
  logic          enq_valid;
  logic          enq_ready;
  logic [DW-1:0] enq_bits;
  logic          deq_valid;
  logic          deq_ready;
  logic [DW-1:0] deq_bits;
  logic [1:0]    count;
  logic          mem_W0_en;
  logic [0:0]    mem_W0_addr;
  logic [DW-1:0] mem_W0_data;
  logic          mem_R0_en;
  logic [0:0]    mem_R0_addr;
  logic [DW-1:0] mem_R0_data;

  logic [DW-1:0] ram [2];

  int checks;
  int failures;

  queue2_ctrl dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .flush       (flush),
    .enq_valid   (enq_valid),
    .enq_ready   (enq_ready),
    .enq_bits    (enq_bits),
    .deq_valid   (deq_valid),
    .deq_ready   (deq_ready),
    .deq_bits    (deq_bits),
    .count       (count),
    .mem_W0_en   (mem_W0_en),
    .mem_W0_addr (mem_W0_addr),
    .mem_W0_data (mem_W0_data),
    .mem_R0_en   (mem_R0_en),
    .mem_R0_addr (mem_R0_addr),
    .mem_R0_data (mem_R0_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_W0_en) ram[mem_W0_addr] <= mem_W0_data;
  end
  assign mem_R0_data = ram[mem_R0_addr];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    enq_valid = 1'b1;
    enq_bits  = 'h7;
    #2;
    checks++; if (enq_ready !== 1'b1) begin failures++; $display("FAIL rst_enq_ready: got %b want 1", enq_ready); end
    checks++; if (deq_valid !== 1'b0) begin failures++; $display("FAIL rst_deq_valid: got %b want 0", deq_valid); end
    checks++; if (count !== 2'd0) begin failures++; $display("FAIL rst_count: got %0d want 0", count); end
    checks++; if (mem_W0_en !== 1'b0) begin failures++; $display("FAIL rst_w0_en: got %b want 0", mem_W0_en); end
    checks++; if (mem_R0_en !== 1'b0) begin failures++; $display("FAIL rst_r0_en: got %b want 0", mem_R0_en); end
    enq_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_fill();
    deq_ready = 1'b0;
    enq_valid = 1'b1;
    enq_bits  = 'h1;
    @(negedge clock);
    checks++; if (count !== 2'd0) begin failures++; $display("FAIL fill_count0: got %0d want 0", count); end
    checks++; if (enq_ready !== 1'b1) begin failures++; $display("FAIL fill_ready0: got %b want 1", enq_ready); end
    checks++; if (mem_W0_en !== 1'b1) begin failures++; $display("FAIL fill_w0_en0: got %b want 1", mem_W0_en); end
    checks++; if (mem_W0_addr !== 1'b0) begin failures++; $display("FAIL fill_addr0: got %0d want 0", mem_W0_addr); end
    checks++; if (deq_valid !== 1'b0) begin failures++; $display("FAIL fill_dv0: got %b want 0", deq_valid); end
    step();
    enq_bits = 'h2;
    @(negedge clock);
    checks++; if (count !== 2'd1) begin failures++; $display("FAIL fill_count1: got %0d want 1", count); end
    checks++; if (deq_valid !== 1'b1) begin failures++; $display("FAIL fill_dv1: got %b want 1", deq_valid); end
    checks++; if (deq_bits !== 'h1) begin failures++; $display("FAIL fill_bits1: got %h want 1", deq_bits); end
    checks++; if (mem_W0_en !== 1'b1) begin failures++; $display("FAIL fill_w0_en1: got %b want 1", mem_W0_en); end
    checks++; if (mem_W0_addr !== 1'b1) begin failures++; $display("FAIL fill_addr1: got %0d want 1", mem_W0_addr); end
    step();
    enq_valid = 1'b0;
    @(negedge clock);
    checks++; if (count !== 2'd2) begin failures++; $display("FAIL fill_count2: got %0d want 2", count); end
    checks++; if (enq_ready !== 1'b0) begin failures++; $display("FAIL fill_ready2: got %b want 0", enq_ready); end
    checks++; if (deq_bits !== 'h1) begin failures++; $display("FAIL fill_stable: got %h want 1", deq_bits); end
    step();
  endtask

  task automatic test_full_both_valid();
    enq_valid = 1'b1;
    enq_bits  = 'h3;
    deq_ready = 1'b1;
    @(negedge clock);
    checks++; if (deq_valid !== 1'b1) begin failures++; $display("FAIL full_dv: got %b want 1", deq_valid); end
    checks++; if (deq_bits !== 'h1) begin failures++; $display("FAIL full_bits: got %h want 1", deq_bits); end
    checks++; if (enq_ready !== 1'b0) begin failures++; $display("FAIL full_ready: got %b want 0", enq_ready); end
    checks++; if (mem_W0_en !== 1'b0) begin failures++; $display("FAIL full_w0_en: got %b want 0", mem_W0_en); end
    step();
    deq_ready = 1'b0;
    @(negedge clock);
    checks++; if (count !== 2'd1) begin failures++; $display("FAIL full_count1: got %0d want 1", count); end
    checks++; if (deq_bits !== 'h2) begin failures++; $display("FAIL full_bits2: got %h want 2", deq_bits); end
    checks++; if (enq_ready !== 1'b1) begin failures++; $display("FAIL full_ready1: got %b want 1", enq_ready); end
    checks++; if (mem_W0_en !== 1'b1) begin failures++; $display("FAIL full_w0_en1: got %b want 1", mem_W0_en); end
    checks++; if (mem_W0_addr !== 1'b0) begin failures++; $display("FAIL full_wrap_addr: got %0d want 0", mem_W0_addr); end
    step();
    enq_valid = 1'b0;
    deq_ready = 1'b1;
    @(negedge clock);
    checks++; if (count !== 2'd2) begin failures++; $display("FAIL drain_count2: got %0d want 2", count); end
    checks++; if (deq_bits !== 'h2) begin failures++; $display("FAIL drain_bits2: got %h want 2", deq_bits); end
    step();
    @(negedge clock);
    checks++; if (count !== 2'd1) begin failures++; $display("FAIL drain_count1: got %0d want 1", count); end
    checks++; if (deq_bits !== 'h3) begin failures++; $display("FAIL drain_bits3: got %h want 3", deq_bits); end
    step();
    deq_ready = 1'b0;
    @(negedge clock);
    checks++; if (count !== 2'd0) begin failures++; $display("FAIL drain_count0: got %0d want 0", count); end
    checks++; if (deq_valid !== 1'b0) begin failures++; $display("FAIL drain_dv0: got %b want 0", deq_valid); end
    step();
  endtask

  // Pointers both sit at 1 on entry; a priming enqueue lands at address 1.
  task automatic test_wrap();
    logic [DW-1:0] exp_bits;
    logic          exp_wa;
    logic          exp_ra;
    enq_valid = 1'b1;
    enq_bits  = 'h9;
    deq_ready = 1'b0;
    @(negedge clock);
    checks++; if (mem_W0_addr !== 1'b1) begin failures++; $display("FAIL wrap_prime_addr: got %0d want 1", mem_W0_addr); end
    step();
    exp_bits = 'h9;
    exp_wa   = 1'b0;
    exp_ra   = 1'b1;
    deq_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      enq_bits = DW'(32'hA + 32'(i));
      @(negedge clock);
      checks++; if (deq_bits !== exp_bits) begin failures++; $display("FAIL wrap_bits[%0d]: got %h want %h", i, deq_bits, exp_bits); end
      checks++; if (count !== 2'd1) begin failures++; $display("FAIL wrap_count[%0d]: got %0d want 1", i, count); end
      checks++; if (mem_W0_addr !== exp_wa) begin failures++; $display("FAIL wrap_waddr[%0d]: got %0d want %0d", i, mem_W0_addr, exp_wa); end
      checks++; if (mem_R0_addr !== exp_ra) begin failures++; $display("FAIL wrap_raddr[%0d]: got %0d want %0d", i, mem_R0_addr, exp_ra); end
      step();
      exp_bits = DW'(32'hA + 32'(i));
      exp_wa   = ~exp_wa;
      exp_ra   = ~exp_ra;
    end
    enq_valid = 1'b0;
    @(negedge clock);
    checks++; if (deq_bits !== 'hE) begin failures++; $display("FAIL wrap_last: got %h want e", deq_bits); end
    checks++; if (mem_R0_addr !== 1'b0) begin failures++; $display("FAIL wrap_last_raddr: got %0d want 0", mem_R0_addr); end
    step();
    deq_ready = 1'b0;
    @(negedge clock);
    checks++; if (count !== 2'd0) begin failures++; $display("FAIL wrap_empty: got %0d want 0", count); end
    step();
  endtask

  task automatic test_flush();
    enq_valid = 1'b1;
    deq_ready = 1'b0;
    enq_bits  = 'h21;
    step();
    enq_bits  = 'h22;
    step();
    flush     = 1'b1;
    enq_bits  = 'h23;
    deq_ready = 1'b1;
    @(negedge clock);
    checks++; if (count !== 2'd2) begin failures++; $display("FAIL flush_pre_count: got %0d want 2", count); end
    checks++; if (enq_ready !== 1'b0) begin failures++; $display("FAIL flush_ready: got %b want 0", enq_ready); end
    checks++; if (deq_valid !== 1'b0) begin failures++; $display("FAIL flush_dv: got %b want 0", deq_valid); end
    checks++; if (mem_W0_en !== 1'b0) begin failures++; $display("FAIL flush_w0_en: got %b want 0", mem_W0_en); end
    step();
    flush     = 1'b0;
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    @(negedge clock);
    checks++; if (count !== 2'd0) begin failures++; $display("FAIL flush_count: got %0d want 0", count); end
    checks++; if (deq_valid !== 1'b0) begin failures++; $display("FAIL flush_dv_after: got %b want 0", deq_valid); end
    checks++; if (mem_R0_en !== 1'b0) begin failures++; $display("FAIL flush_r0_en: got %b want 0", mem_R0_en); end
    step();
    enq_valid = 1'b1;
    enq_bits  = 'h31;
    @(negedge clock);
    checks++; if (mem_W0_addr !== 1'b0) begin failures++; $display("FAIL flush_ptr_zero: got %0d want 0", mem_W0_addr); end
    step();
    enq_valid = 1'b0;
    deq_ready = 1'b1;
    @(negedge clock);
    checks++; if (deq_bits !== 'h31) begin failures++; $display("FAIL flush_refill: got %h want 31", deq_bits); end
    step();
    deq_ready = 1'b0;
  endtask

`ifdef QUEUE2_CTRL_FLOW_EN
  task automatic test_flow();
    enq_valid = 1'b1;
    enq_bits  = 'h55;
    deq_ready = 1'b1;
    @(negedge clock);
    checks++; if (deq_valid !== 1'b1) begin failures++; $display("FAIL flow_dv: got %b want 1", deq_valid); end
    checks++; if (deq_bits !== 'h55) begin failures++; $display("FAIL flow_bits: got %h want 55", deq_bits); end
    checks++; if (mem_W0_en !== 1'b0) begin failures++; $display("FAIL flow_w0_en: got %b want 0", mem_W0_en); end
    step();
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    @(negedge clock);
    checks++; if (count !== 2'd0) begin failures++; $display("FAIL flow_count: got %0d want 0", count); end
    checks++; if (deq_valid !== 1'b0) begin failures++; $display("FAIL flow_dv_after: got %b want 0", deq_valid); end
    step();
  endtask
`else
  task automatic test_no_flow();
    enq_valid = 1'b1;
    enq_bits  = 'h55;
    deq_ready = 1'b1;
    @(negedge clock);
    checks++; if (deq_valid !== 1'b0) begin failures++; $display("FAIL noflow_dv: got %b want 0", deq_valid); end
    checks++; if (mem_W0_en !== 1'b1) begin failures++; $display("FAIL noflow_w0_en: got %b want 1", mem_W0_en); end
    step();
    enq_valid = 1'b0;
    @(negedge clock);
    checks++; if (deq_valid !== 1'b1) begin failures++; $display("FAIL noflow_dv1: got %b want 1", deq_valid); end
    checks++; if (deq_bits !== 'h55) begin failures++; $display("FAIL noflow_bits: got %h want 55", deq_bits); end
    checks++; if (count !== 2'd1) begin failures++; $display("FAIL noflow_count: got %0d want 1", count); end
    step();
    deq_ready = 1'b0;
    @(negedge clock);
    checks++; if (count !== 2'd0) begin failures++; $display("FAIL noflow_count0: got %0d want 0", count); end
    step();
  endtask
`endif

  task automatic test_reset_mid();
    enq_valid = 1'b1;
    enq_bits  = 'h66;
    deq_ready = 1'b0;
    step();
    enq_bits = 'h77;
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (enq_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready: got %b want 1", enq_ready); end
    checks++; if (deq_valid !== 1'b0) begin failures++; $display("FAIL midrst_dv: got %b want 0", deq_valid); end
    checks++; if (count !== 2'd0) begin failures++; $display("FAIL midrst_count: got %0d want 0", count); end
    checks++; if (mem_W0_en !== 1'b0) begin failures++; $display("FAIL midrst_w0_en: got %b want 0", mem_W0_en); end
    enq_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    step();
    @(negedge clock);
    checks++; if (count !== 2'd0) begin failures++; $display("FAIL midrst_after: got %0d want 0", count); end
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    checks    = 0;
    failures  = 0;
    reset_n   = 1'b0;
    flush     = 1'b0;
    enq_valid = 1'b0;
    enq_bits  = '0;
    deq_ready = 1'b0;
    test_reset();
    test_fill();
    test_full_both_valid();
    test_wrap();
    test_flush();
`ifdef QUEUE2_CTRL_FLOW_EN
    test_flow();
`else
    test_no_flow();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/queue2_ctrl.md
QUEUE2_CTRL -- requirements
Module: queue2_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 105, payload width in bits.
REQ-002 SHALL have parameter DEPTH, default 2, entry count; power of two, minimum 2; AW = log2(DEPTH).
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port flush  input  1  synchronous discard of all stored entries.
REQ-006 SHALL have ports enq_valid (input, 1), enq_ready (output, 1), enq_bits (input, DATA_W): producer handshake.
REQ-007 SHALL have ports deq_valid (output, 1), deq_ready (input, 1), deq_bits (output, DATA_W): consumer handshake.
REQ-008 SHALL have port count  output  AW+1  number of stored entries, 0..DEPTH.
REQ-009 SHALL have ports mem_W0_en (output, 1), mem_W0_addr (output, AW), mem_W0_data (output, DATA_W): RAM write port drive.
REQ-010 SHALL have ports mem_R0_en (output, 1), mem_R0_addr (output, AW), mem_R0_data (input, DATA_W): RAM read port; read is combinational.

Function
REQ-011 SHALL hold state enq_ptr[AW-1:0], deq_ptr[AW-1:0], maybe_full; no other storage for payload.
REQ-012 SHALL derive empty = (enq_ptr==deq_ptr) & !maybe_full and full = (enq_ptr==deq_ptr) & maybe_full.
REQ-013 SHALL drive enq_ready = !full & !flush and deq_valid = !empty & !flush (flow case per REQ-027).
REQ-014 SHALL define do_enq = enq_valid & enq_ready and do_deq = deq_valid & deq_ready; transfer occurs only on these.
REQ-015 SHALL drive mem_W0_en = do_enq, mem_W0_addr = enq_ptr, mem_W0_data = enq_bits, same cycle.
REQ-016 SHALL drive mem_R0_en = !empty, mem_R0_addr = deq_ptr, deq_bits = mem_R0_data; zero-cycle read latency.
REQ-017 SHALL increment enq_ptr on do_enq and deq_ptr on do_deq, wrapping DEPTH-1 -> 0.
REQ-018 SHALL set maybe_full <= do_enq when do_enq != do_deq; otherwise hold.
REQ-019 SHALL compute count = {maybe_full & ptr_match, enq_ptr - deq_ptr} modulo DEPTH, i.e. DEPTH when full.
REQ-020 SHALL, on simultaneous do_enq and do_deq (neither empty nor full), advance both pointers and keep count unchanged.
REQ-021 SHALL, when full, ignore enq_valid (no write); a do_deq that cycle frees one entry visible next cycle.
REQ-022 SHALL, when empty and flow disabled, expose no data; first enqueued entry appears on deq_valid one cycle after do_enq.
REQ-023 SHALL, on flush=1, zero both pointers and maybe_full at next edge; flush beats any concurrent enq/deq (none transfer).
REQ-024 SHALL keep deq_bits stable while deq_valid & !deq_ready.

Reset
REQ-025 SHALL, while reset_n=0, asynchronously force enq_ptr=0, deq_ptr=0, maybe_full=0; outputs: enq_ready=1, deq_valid=0, count=0, mem_W0_en=0, mem_R0_en=0.
REQ-026 SHALL treat reset mid-operation as discarding all entries; RAM contents are not cleared and are never read until rewritten.

Configuration
REQ-027 SHALL, with QUEUE2_CTRL_FLOW_EN defined, when empty: deq_valid = enq_valid, deq_bits = enq_bits, and suppress mem_W0_en/pointer update if deq_ready (zero-latency bypass); without it, REQ-022 holds.

Structure
REQ-028 SHALL place DATA_W default, DEPTH default and the count-width function in shared package queue2_pkg.
REQ-029 SHALL implement each pointer as one instance of sub-module queue_ptr (wrap counter with inc and clear inputs).

Verification
REQ-030 SHALL test reset: reset_n=0 mid-traffic -> enq_ready=1, deq_valid=0, count=0 immediately, no write enable.
REQ-031 SHALL test fill: two enqs 0x1, 0x2 with deq_ready=0 -> count 1 then 2, enq_ready=0 after second, mem_W0_addr 0 then 1.
REQ-032 SHALL test full plus both valid: deq_ready=1, enq_valid=1 when full -> deq 0x1, no write, count=1; next cycle enq accepted.
REQ-033 SHALL test wrap: 5 back-to-back enq/deq of 0xA..0xE at steady count 1 -> output order preserved, pointers wrap 1->0.
REQ-034 SHALL test flush with enq_valid=1 at count 2 -> no write, count=0 next cycle, deq_valid=0.
REQ-035 SHALL test flow (macro defined): empty, enq 0x55 with deq_ready=1 -> deq_bits=0x55 same cycle, mem_W0_en=0, count stays 0.
